stopwatch_cmd_arbiter: RTL

Command front-end for the stopwatch core. It debounces the synchronized local push-buttons and accepts remote commands over a valid/ready port. It arbitrates between the two sources and emits single-cycle one-hot commands on the core's 4-bit command bus. It sits between the `sync_input` stages and the stopwatch FSM, replacing the direct button connection.

---
 rtl/stopwatch_cmd_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_cmd_arbiter.sv
// Stopwatch command front-end: debounced local buttons and a valid/ready remote port arbitrated
// into single-cycle one-hot commands. Remote port is built only when STOPWATCH_CMD_REMOTE_EN is defined.
module stopwatch_cmd_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [3:0] rem_cmd,
  input  logic       rem_valid,
  output logic       rem_ready,
  output logic [3:0] cmd,
  output logic       cmd_src,
  output logic       busy,
  output logic       rem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam bit          NO_GAP    = (GAP_CYCLES == 0);
  localparam logic [3:0]  CMD_RESET = 4'b1000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  logic [3:0]  cand_r;
  logic [3:0]  stable_r;
  logic [15:0] db_cnt_r;
  logic        local_req_s;

  logic        loc_full_r;
  logic [3:0]  loc_slot_r;
  logic        rem_full_s;
  logic [3:0]  rem_slot_s;

  state_t      state_r;
  state_t      state_nx;
  logic [7:0]  gap_cnt_r;
  logic [7:0]  gap_nx;
  logic [3:0]  cmd_r;
  logic [3:0]  cmd_nx;
  logic        cmd_src_r;
  logic        busy_r;
  logic        last_src_r;
  logic        issue_s;
  logic        pick_src_s;
  logic [3:0]  pick_cmd_s;
  logic        loc_clr_s;

  // A press is the settle edge that moves the stable value from idle to a single button.
  assign local_req_s = (btn == cand_r) && (db_cnt_r == DB_LAST) &&
                       (stable_r == 4'd0) && is_onehot(cand_r);

  // Debounce: candidate must hold for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r   <= 4'd0;
      stable_r <= 4'd0;
      db_cnt_r <= 16'd0;
    end else if (btn != cand_r) begin
      cand_r   <= btn;
      db_cnt_r <= 16'd0;
    end else if (db_cnt_r == DB_LAST) begin
      stable_r <= cand_r;
    end else begin
      db_cnt_r <= db_cnt_r + 16'd1;
    end
  end

  assign loc_clr_s = issue_s && !pick_src_s;

  // Local slot: a freed slot accepts a new press on the same edge; RESET always overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_full_r <= 1'b0;
      loc_slot_r <= 4'd0;
    end else if (local_req_s && (loc_clr_s || !loc_full_r || (cand_r == CMD_RESET))) begin
      loc_full_r <= 1'b1;
      loc_slot_r <= cand_r;
    end else if (loc_clr_s) begin
      loc_full_r <= 1'b0;
    end
  end

`ifdef STOPWATCH_CMD_REMOTE_EN
  logic       rem_empty_r;
  logic [3:0] rem_slot_r;
  logic       rem_err_r;
  logic       rem_take_s;

  assign rem_take_s = rem_valid && rem_empty_r;

  // Remote slot: one entry, ready while empty; malformed commands are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_empty_r <= 1'b1;
      rem_slot_r  <= 4'd0;
      rem_err_r   <= 1'b0;
    end else begin
      rem_err_r <= rem_take_s && !is_onehot(rem_cmd);
      if (rem_take_s && is_onehot(rem_cmd)) begin
        rem_empty_r <= 1'b0;
        rem_slot_r  <= rem_cmd;
      end else if (issue_s && pick_src_s) begin
        rem_empty_r <= 1'b1;
      end
    end
  end

  assign rem_full_s = !rem_empty_r;
  assign rem_slot_s = rem_slot_r;
  assign rem_ready  = rem_empty_r;
  assign rem_err    = rem_err_r;
`else
  logic unused_rem_s;
  assign unused_rem_s = ^{rem_cmd, rem_valid};
  assign rem_full_s   = 1'b0;
  assign rem_slot_s   = 4'd0;
  assign rem_ready    = 1'b0;
  assign rem_err      = 1'b0;
`endif

  // Winner selection: RESET first (local on a tie), then alternate against the last source.
  always_comb begin
    pick_src_s = 1'b0;
    if (loc_full_r && (loc_slot_r == CMD_RESET)) begin
      pick_src_s = 1'b0;
    end else if (rem_full_s && (rem_slot_s == CMD_RESET)) begin
      pick_src_s = 1'b1;
    end else if (loc_full_r && rem_full_s) begin
      pick_src_s = !last_src_r;
    end else if (rem_full_s) begin
      pick_src_s = 1'b1;
    end else begin
      pick_src_s = 1'b0;
    end
    pick_cmd_s = pick_src_s ? rem_slot_s : loc_slot_r;
  end

  // Next-state and command decode.
  always_comb begin
    state_nx = state_r;
    gap_nx   = gap_cnt_r;
    cmd_nx   = 4'd0;
    issue_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (loc_full_r || rem_full_s) begin
          issue_s  = 1'b1;
          cmd_nx   = pick_cmd_s;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (NO_GAP) begin
          state_nx = IDLE;
        end else begin
          state_nx = GAP;
          gap_nx   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_r == 8'd0) begin
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gap_cnt_r  <= 8'd0;
      cmd_r      <= 4'd0;
      cmd_src_r  <= 1'b0;
      busy_r     <= 1'b0;
      last_src_r <= 1'b1;
    end else begin
      state_r   <= state_nx;
      gap_cnt_r <= gap_nx;
      cmd_r     <= cmd_nx;
      busy_r    <= (state_nx != IDLE);
      if (issue_s) begin
        cmd_src_r  <= pick_src_s;
        last_src_r <= pick_src_s;
      end
    end
  end

  assign cmd     = cmd_r;
  assign cmd_src = cmd_src_r;
  assign busy    = busy_r;

endmodule
